// File: rtl/arm_lp_pkg.sv
// Shared encodings for the ARM-LP execute/memory slice: opcode match values,
// op_type codes and ALU control codes.
package arm_lp_pkg;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  typedef enum logic [2:0] {
    OPT_R   = 3'd0,
    OPT_D   = 3'd1,
    OPT_B   = 3'd2,
    OPT_CB  = 3'd3,
    OPT_INV = 3'd7
  } op_type_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b1111;

endpackage

// File: rtl/arm_lp_alu.sv
// 32-bit ALU with carry (add carry-out, subtract no-borrow) and zero flag.
module arm_lp_alu
  import arm_lp_pkg::*;
(
  input  logic [3:0]  alu_control_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        carry_o
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // Bit 32 of the extended difference is the borrow.
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = 32'd0;
    carry_o  = 1'b0;
    case (alu_control_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_ORR:  result_o = a_i | b_i;
      ALU_ADD:  begin result_o = sum[31:0];  carry_o = sum[32];   end
      ALU_SUB:  begin result_o = diff[31:0]; carry_o = ~diff[32]; end
      ALU_PASS: result_o = b_i;
      default:  result_o = 32'd0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/arm_lp_dcache.sv
// Word-addressed data cache with a registered write-back mux; reset clears
// every word and the write-back register.
module arm_lp_dcache #(
  parameter int DEPTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  output logic [31:0] wb_data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      wb_data_q;
  logic [31:0]      wb_data_d;
  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  assign idx         = addr_i[IDX_W+1:2];
  assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
  // Nonblocking update means a same-edge read sees the pre-write word.
  assign wb_data_d   = (mem_read_i && mem_to_reg_i) ? mem_q[idx] : addr_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_data_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      wb_data_q <= wb_data_d;
      if (mem_write_i) mem_q[idx] <= store_data_i;
    end
  end

  assign wb_data_o = wb_data_q;

endmodule

// File: rtl/arm_lp_decoder.sv
// Combinational controller: decodes instr[31:21] into control flags,
// op_type, ALU control and register IDs.
module arm_lp_decoder
  import arm_lp_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_o,
  output logic        branch_o,
  output logic        ubranch_o,
  output logic [2:0]  op_type_o,
  output logic [3:0]  alu_control_o,
  output logic [4:0]  read_reg1_o,
  output logic [4:0]  read_reg2_o,
  output logic [4:0]  write_reg_o
);

  op_type_e    op_type;
  logic [10:0] opcode;
  logic        unused_instr;

  assign opcode       = instr_i[31:21];
  assign unused_instr = ^instr_i[15:10];

  always_comb begin
    reg_write_o   = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_o     = 1'b0;
    branch_o      = 1'b0;
    ubranch_o     = 1'b0;
    op_type       = OPT_INV;
    alu_control_o = ALU_NONE;
    if (opcode == OP_ADD || opcode == OP_SUB ||
        opcode == OP_AND || opcode == OP_ORR) begin
      op_type     = OPT_R;
      reg_write_o = 1'b1;
      if (opcode == OP_ADD)      alu_control_o = ALU_ADD;
      else if (opcode == OP_SUB) alu_control_o = ALU_SUB;
      else if (opcode == OP_AND) alu_control_o = ALU_AND;
      else                       alu_control_o = ALU_ORR;
    end else if (opcode == OP_LDUR) begin
      op_type       = OPT_D;
      alu_control_o = ALU_ADD;
      alu_src_o     = 1'b1;
      mem_read_o    = 1'b1;
      mem_to_reg_o  = 1'b1;
      reg_write_o   = 1'b1;
    end else if (opcode == OP_STUR) begin
      op_type       = OPT_D;
      alu_control_o = ALU_ADD;
      alu_src_o     = 1'b1;
      mem_write_o   = 1'b1;
    end else if (instr_i[31:24] == OP_CBZ) begin
      op_type       = OPT_CB;
      alu_control_o = ALU_PASS;
      branch_o      = 1'b1;
    end else if (instr_i[31:26] == OP_B) begin
      op_type       = OPT_B;
      alu_control_o = ALU_NONE;
      ubranch_o     = 1'b1;
    end
  end

  assign op_type_o   = op_type;
  assign read_reg1_o = instr_i[9:5];
  assign write_reg_o = instr_i[4:0];
  // Only R-type takes its second source from Rm; everything else uses Rt.
  assign read_reg2_o = (op_type == OPT_R) ? instr_i[20:16] : instr_i[4:0];

endmodule

// File: rtl/alu_ctrl_dcache.sv
// Execute-and-memory slice: decoder, ALU and data cache wired together.
module alu_ctrl_dcache
  import arm_lp_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] store_data,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        branch,
  output logic        ubranch,
  output logic [2:0]  op_type,
  output logic [3:0]  alu_control,
  output logic [4:0]  read_reg1,
  output logic [4:0]  read_reg2,
  output logic [4:0]  write_reg,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry,
  output logic [31:0] wb_data
);

  arm_lp_decoder u_decoder (
    .instr_i       (instruction),
    .reg_write_o   (reg_write),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .mem_to_reg_o  (mem_to_reg),
    .alu_src_o     (alu_src),
    .branch_o      (branch),
    .ubranch_o     (ubranch),
    .op_type_o     (op_type),
    .alu_control_o (alu_control),
    .read_reg1_o   (read_reg1),
    .read_reg2_o   (read_reg2),
    .write_reg_o   (write_reg)
  );

  arm_lp_alu u_alu (
    .alu_control_i (alu_control),
    .a_i           (read_data1),
    .b_i           (read_data2),
    .result_o      (result),
    .zero_o        (zero),
    .carry_o       (carry)
  );

  arm_lp_dcache #(.DEPTH(DEPTH)) u_dcache (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .addr_i       (result),
    .store_data_i (store_data),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .mem_to_reg_i (mem_to_reg),
    .wb_data_o    (wb_data)
  );

endmodule

// File: tb/tb_alu_ctrl_dcache.sv
// Bench for alu_ctrl_dcache: directed cases plus randomized instruction
// streams against a table-driven decode/ALU model and an array memory model.
module tb_alu_ctrl_dcache;

  localparam int DEPTH = 64;

  logic        clock;
  logic        reset_n;
  logic [31:0] instruction, read_data1, read_data2, store_data;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, ubranch;
  logic [2:0]  op_type;
  logic [3:0]  alu_control;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] result, wb_data;
  logic        zero, carry;

  int          n_compared;
  int          n_mismatched;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];

  alu_ctrl_dcache #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction),
    .read_data1(read_data1), .read_data2(read_data2), .store_data(store_data),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch), .ubranch(ubranch),
    .op_type(op_type), .alu_control(alu_control), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .write_reg(write_reg), .result(result),
    .zero(zero), .carry(carry), .wb_data(wb_data)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference decode. flags = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, ubranch}
  function automatic void model_decode(input logic [31:0] ins, output logic [6:0] flags,
                                       output logic [2:0] opt, output logic [3:0] ctl,
                                       output logic [4:0] r2);
    int op11;
    op11  = int'(ins >> 21);
    flags = 7'b0000000; opt = 3'd7; ctl = 4'hF;
    case (op11)
      'h458: begin flags = 7'b1000000; opt = 3'd0; ctl = 4'd2; end
      'h658: begin flags = 7'b1000000; opt = 3'd0; ctl = 4'd6; end
      'h450: begin flags = 7'b1000000; opt = 3'd0; ctl = 4'd0; end
      'h550: begin flags = 7'b1000000; opt = 3'd0; ctl = 4'd1; end
      'h7C2: begin flags = 7'b1101100; opt = 3'd1; ctl = 4'd2; end
      'h7C0: begin flags = 7'b0010100; opt = 3'd1; ctl = 4'd2; end
      default: begin
        if ((ins >> 24) == 32'hB4) begin flags = 7'b0000010; opt = 3'd3; ctl = 4'd7; end
        else if ((ins >> 26) == 32'h05) begin flags = 7'b0000001; opt = 3'd2; ctl = 4'hF; end
      end
    endcase
    r2 = (opt == 3'd0) ? 5'((ins >> 16) & 32'h1F) : 5'(ins & 32'h1F);
  endfunction

  function automatic void model_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic cy);
    longint la, lb;
    la = longint'(a); lb = longint'(b);
    res = 32'd0; cy = 1'b0;
    case (ctl)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: begin res = 32'(la + lb); cy = (la + lb) >= 64'h1_0000_0000; end
      4'd6: begin res = 32'(la - lb); cy = (la >= lb); end
      4'd7: res = b;
      default: res = 32'd0;
    endcase
  endfunction

  // driver: apply one cycle, check combinational outputs, then check wb_data after the edge
  task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] sd, input logic rst_n);
    logic [6:0]  ef;
    logic [2:0]  eo;
    logic [3:0]  ec;
    logic [4:0]  er2;
    logic [31:0] er;
    logic [31:0] got_exp;
    logic        ecy;
    int          idx;
    instruction = ins; read_data1 = a; read_data2 = b; store_data = sd; reset_n = rst_n;
    #1;
    model_decode(ins, ef, eo, ec, er2);
    model_alu(ec, a, b, er, ecy);
    check("flags", 32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, ubranch}), 32'(ef));
    check("op_type", 32'(op_type), 32'(eo));
    check("alu_control", 32'(alu_control), 32'(ec));
    check("read_reg1", 32'(read_reg1), (ins >> 5) & 32'h1F);
    check("read_reg2", 32'(read_reg2), 32'(er2));
    check("write_reg", 32'(write_reg), ins & 32'h1F);
    check("result", result, er);
    check("zero", 32'(zero), 32'(er == 32'd0));
    check("carry", 32'(carry), 32'(ecy));
    idx = int'((er / 4) % DEPTH);
    if (!rst_n) begin
      exp_q.push_back(32'd0);
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    end else begin
      exp_q.push_back((ef[5] && ef[3]) ? model_mem[idx] : er);
      if (ef[4]) model_mem[idx] = sd;
    end
    @(posedge clock);
    #1;
    got_exp = exp_q.pop_front();
    check("wb_data", wb_data, got_exp);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = int'($urandom_range(0, 8));
    case (k)
      0: return {11'h458, r[20:0]};
      1: return {11'h658, r[20:0]};
      2: return {11'h450, r[20:0]};
      3: return {11'h550, r[20:0]};
      4: return {11'h7C2, r[20:0]};
      5: return {11'h7C0, r[20:0]};
      6: return {8'hB4, r[23:0]};
      7: return {6'h05, r[25:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    n_compared = 0; n_mismatched = 0;
    instruction = 32'd0; read_data1 = 32'd0; read_data2 = 32'd0; store_data = 32'd0;
    reset_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    @(posedge clock); #1;

    step(32'h0000_0000, 32'd0, 32'd0, 32'd0, 1'b0);
    // directed cases
    step(32'h8B02_0020, 32'd5, 32'd7, 32'd0, 1'b1);
    step(32'hCB02_0020, 32'h10, 32'h10, 32'd0, 1'b1);
    step(32'h8B02_0020, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    step(32'hF800_8083, 32'h100, 32'd8, 32'hDEAD_BEEF, 1'b1);
    step(32'hF840_8083, 32'h100, 32'd8, 32'd0, 1'b1);
    step(32'hB400_0045, 32'd9, 32'd0, 32'd0, 1'b1);
    step(32'hB400_0045, 32'd9, 32'd3, 32'd0, 1'b1);
    step(32'h1400_0004, 32'd1, 32'd2, 32'd0, 1'b1);
    step(32'h0000_0000, 32'd1, 32'd2, 32'd0, 1'b1);
    // wrap-around alias of index 2 (0x108 mod 0x100) sees the same word
    step(32'hF840_8083, 32'h200, 32'd8, 32'd0, 1'b1);
    step(32'hF800_8083, 32'h40, 32'd4, 32'h1234_5678, 1'b1);
    step(32'hF840_8083, 32'h40, 32'd4, 32'd0, 1'b0);
    step(32'hF840_8083, 32'h40, 32'd4, 32'd0, 1'b1);
    step(32'hF840_8083, 32'h100, 32'd8, 32'd0, 1'b1);

    // randomized streams on a small address window so loads hit earlier stores
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = 32'($urandom_range(0, 63)); b = 32'($urandom_range(0, 63));
      end else begin
        a = $urandom(); b = $urandom();
      end
      if ($urandom_range(0, 9) == 0) b = a;
      step(rand_instr(), a, b, $urandom(), ($urandom_range(0, 39) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_dcache.md
# alu_ctrl_dcache

Execute-and-memory slice of the ARM-LP single-cycle LEGv8-subset processor. Bundles three parts:
- the instruction decoder/controller;
- the 32-bit ALU;
- a synchronous word-addressed data cache.

Sits between the instruction cache and operand prep (upstream) and the register-file write-back and PC logic (downstream).

## Interface
Parameters:
- DEPTH, 64: data-cache words of 32 bits; index = addr[log2(DEPTH)+1:2].

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- instruction  in  32  current instruction word.
- read_data1  in  32  ALU operand A (Rn value).
- read_data2  in  32  ALU operand B, already muxed by operand prep per alu_src.
- store_data  in  32  Rt value written to memory on STUR.
- reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, ubranch  out  1 each  control flags.
- op_type  out  3  0=R, 1=D, 2=B, 3=CB, 7=invalid.
- alu_control  out  4  ALU operation code.
- read_reg1, read_reg2, write_reg  out  5 each  register IDs.
- result  out  32  ALU result, combinational.
- zero  out  1  result == 0.
- carry  out  1  ALU carry.
- wb_data  out  32  registered write-back data.

## Operation
Controller (combinational), keyed on instruction[31:21].

| Instruction | Match | op_type | alu_control | Asserted flags |
|---|---|---|---|---|
| ADD | 0x458 | R | 0010 | reg_write |
| SUB | 0x658 | R | 0110 | reg_write |
| AND | 0x450 | R | 0000 | reg_write |
| ORR | 0x550 | R | 0001 | reg_write |
| LDUR | 0x7C2 | D | 0010 | alu_src, mem_read, mem_to_reg, reg_write |
| STUR | 0x7C0 | D | 0010 | alu_src, mem_write |
| CBZ | [31:24]=0xB4 | CB | 0111 | branch |
| B | [31:26]=0x05 | B | 1111 | ubranch |

- Any other encoding: all flags 0, op_type 7, alu_control 1111.
- Register IDs for every decode:
  - read_reg1 = instr[9:5].
  - write_reg = instr[4:0].
  - read_reg2 = instr[20:16] for R-type, instr[4:0] otherwise.

ALU (combinational):

| alu_control | result | carry |
|---|---|---|
| 0000 | A & B | 0 |
| 0001 | A \| B | 0 |
| 0010 | A + B | bit 32 of the 33-bit sum |
| 0110 | A − B | 1 when A ≥ B unsigned (no borrow) |
| 0111 | B | 0 |
| any other code | 0 | 0 |

- Arithmetic is modulo 2^32.
- zero = (result == 0) for every code.

Data cache:
- Address = result.
- On a rising edge with mem_write=1, mem[idx] <= store_data.
- On every rising edge:
  - wb_data <= mem[idx] if mem_read && mem_to_reg;
  - otherwise wb_data <= result.
- Read and write are never asserted together by decode. If a write and read hit the same index, the read returns the old contents.
- Address bits [1:0] and the bits above the index are ignored, so addresses wrap modulo 4·DEPTH.

## Timing
- Controller, ALU, result, zero and carry are combinational from the inputs; zero latency.
- Memory write commits at the clock edge where mem_write=1.
- wb_data has 1-cycle latency: it reflects the inputs sampled at the previous edge.
- Reset (reset_n=0 at an edge):
  - wb_data <= 0;
  - all memory words <= 0;
  - writes in that cycle are suppressed.
- Combinational outputs are unaffected by reset.
- Reset asserted mid-sequence discards any pending load: wb_data is 0 on the next cycle.

## Structure
- Shared package arm_lp_pkg holds:
  - opcode constants (ADD/SUB/AND/ORR/LDUR/STUR/CBZ/B);
  - op_type encodings;
  - ALU control codes.
- Natural sub-modules: arm_lp_decoder (combinational controller), arm_lp_alu, arm_lp_dcache. The top level only wires them together.

## Test plan
- **R-type ADD and SUB**
  - ADD instruction 0x8B020020, A=5, B=7 -> reg_write=1, op_type=0, alu_control=0010, read_reg1=1, read_reg2=2, write_reg=0, result=12, zero=0, carry=0.
  - Next edge: wb_data=12.
  - Same encoding with opcode 0x658, A=B=0x10 -> result=0, zero=1, carry=1.
- **ADD wrap-around**
  - A=0xFFFFFFFF, B=1, ADD -> result=0, zero=1, carry=1.
- **STUR then LDUR**
  - STUR 0xF8008083 with A=0x100, B=8, store_data=0xDEADBEEF -> mem_write=1, read_reg2=3.
  - LDUR 0xF8408083 with the same operands -> mem_read=mem_to_reg=alu_src=1.
  - One edge later: wb_data=0xDEADBEEF.
- **CBZ and B**
  - CBZ 0xB4000045 with B=0 -> branch=1, op_type=3, alu_control=0111, read_reg2=5, zero=1.
  - Same with B=3 -> zero=0.
  - B 0x14000004 -> ubranch=1, op_type=2, reg_write=0.
- **Invalid encoding and reset**
  - Instruction 0x00000000 -> all flags 0, op_type=7, result=0.
  - Assert reset_n=0 for one edge after a store -> wb_data=0, and a subsequent LDUR from that address returns 0.
